xadc_scan_sequencer: RTL and testbench



---
 rtl/xadc_scan_sequencer_if.sv | 21 ++
 rtl/xadc_scan_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_xadc_scan_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/xadc_scan_sequencer_if.sv
// DRP bundle between the scan sequencer (master) and the XADC primitive (slave).
interface xadc_scan_sequencer_if;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic [15:0] drp_do;
    logic        drp_drdy;

    modport master (
        output drp_daddr,
        output drp_den,
        input  drp_do,
        input  drp_drdy
    );

    modport slave (
        input  drp_daddr,
        input  drp_den,
        output drp_do,
        output drp_drdy
    );
endinterface

// File: rtl/xadc_scan_sequencer.sv
// XADC DRP scan engine: walks ADDR_LIST once per interval, stores 12-bit codes and
// over-range flags in a bank read through a registered random-access port.
// Optional feature macro: XADC_SCAN_AVG_EN (average 2^AVG_LOG2 conversions per channel).
module xadc_scan_sequencer #(
    parameter int unsigned          NUM_CH      = 13,
    parameter logic [NUM_CH*7-1:0]  ADDR_LIST   = {7'h1E, 7'h1D, 7'h1C, 7'h1B, 7'h1A, 7'h19, 7'h18,
                                                   7'h17, 7'h16, 7'h06, 7'h02, 7'h01, 7'h00},
    parameter int unsigned          WAIT_CYCLES = 10_000_000,
    parameter int unsigned          AVG_LOG2    = 2,
    parameter logic [15:0]          OVR_THRESH  = 16'hFFD0,
    parameter int unsigned          TMO_CYCLES  = 255,
    localparam int unsigned         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  pclk,
    input  logic                  rst,
    xadc_scan_sequencer_if.master drp,
    input  logic [CH_W-1:0]       rd_ch,
    output logic [11:0]           rd_data,
    output logic                  rd_ovr,
    output logic                  sweep_done,
    output logic                  tmo_err
);

    localparam int unsigned WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned TMO_W  = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;

    // Elaboration-time parameter range checks
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("xadc_scan_sequencer: NUM_CH must be 1..16");
    end
    if (AVG_LOG2 > 4) begin : g_bad_avg_log2
        $error("xadc_scan_sequencer: AVG_LOG2 must be 0..4");
    end
    if (WAIT_CYCLES < 1 || TMO_CYCLES < 1) begin : g_bad_cycles
        $error("xadc_scan_sequencer: WAIT_CYCLES and TMO_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, WAIT, REQ, RESP, ACC, NEXT} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [11:0]       sample_q, sample_d;
    logic              ovrs_q, ovrs_d;
    logic              tmo_err_d;
    logic              sweep_d;
    logic              ovr_hit_c;
    logic              bank_we_c;
    logic [11:0]       bank_wdata_c;
    logic              bank_wovr_c;

    logic [11:0]       bank_q [NUM_CH];
    logic [NUM_CH-1:0] ovr_q;

`ifdef XADC_SCAN_AVG_EN
    localparam int unsigned ACC_W  = 12 + AVG_LOG2;
    localparam int unsigned SCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              ovr_acc_q, ovr_acc_d;
    logic [ACC_W-1:0]  sum_c;
`endif

    // Next-state and datapath decode
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        wait_d       = wait_q;
        tmo_d        = tmo_q;
        sample_d     = sample_q;
        ovrs_d       = ovrs_q;
        tmo_err_d    = tmo_err;
        sweep_d      = 1'b0;
        ovr_hit_c    = 1'b0;
        bank_we_c    = 1'b0;
        bank_wdata_c = sample_q;
        bank_wovr_c  = ovrs_q;
`ifdef XADC_SCAN_AVG_EN
        acc_d        = acc_q;
        scnt_d       = scnt_q;
        ovr_acc_d    = ovr_acc_q;
        sum_c        = acc_q + ACC_W'(sample_q);
`endif
        case (state_q)
            IDLE: begin
                wait_d  = '0;
                ch_d    = '0;
`ifdef XADC_SCAN_AVG_EN
                scnt_d    = '0;
                acc_d     = '0;
                ovr_acc_d = 1'b0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (wait_q == WAIT_W'(WAIT_CYCLES - 1)) begin
                    state_d = REQ;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            REQ: begin
                tmo_d   = '0;
                state_d = RESP;
            end
            RESP: begin
                // drdy takes priority over a timeout expiring in the same cycle
                if (drp.drp_drdy) begin
                    ovr_hit_c = (drp.drp_do > OVR_THRESH);
                    sample_d  = ovr_hit_c ? 12'hFFF : drp.drp_do[15:4];
                    ovrs_d    = ovr_hit_c;
                    state_d   = ACC;
                end else if (tmo_q == TMO_W'(TMO_CYCLES - 1)) begin
                    tmo_err_d = 1'b1;
`ifdef XADC_SCAN_AVG_EN
                    scnt_d    = '0;
                    acc_d     = '0;
                    ovr_acc_d = 1'b0;
`endif
                    state_d   = NEXT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ACC: begin
`ifdef XADC_SCAN_AVG_EN
                if (scnt_q == SCNT_W'((1 << AVG_LOG2) - 1)) begin
                    bank_we_c    = 1'b1;
                    bank_wdata_c = 12'(sum_c >> AVG_LOG2);
                    bank_wovr_c  = ovr_acc_q | ovrs_q;
                    acc_d        = '0;
                    scnt_d       = '0;
                    ovr_acc_d    = 1'b0;
                    state_d      = NEXT;
                end else begin
                    acc_d     = sum_c;
                    scnt_d    = scnt_q + SCNT_W'(1);
                    ovr_acc_d = ovr_acc_q | ovrs_q;
                    state_d   = REQ;
                end
`else
                bank_we_c    = 1'b1;
                bank_wdata_c = sample_q;
                bank_wovr_c  = ovrs_q;
                state_d      = NEXT;
`endif
            end
            NEXT: begin
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    sweep_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered DRP/status outputs
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q        <= IDLE;
            ch_q           <= '0;
            wait_q         <= '0;
            tmo_q          <= '0;
            sample_q       <= '0;
            ovrs_q         <= 1'b0;
            tmo_err        <= 1'b0;
            sweep_done     <= 1'b0;
            drp.drp_den    <= 1'b0;
            drp.drp_daddr  <= ADDR_LIST[6:0];
`ifdef XADC_SCAN_AVG_EN
            acc_q          <= '0;
            scnt_q         <= '0;
            ovr_acc_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            wait_q         <= wait_d;
            tmo_q          <= tmo_d;
            sample_q       <= sample_d;
            ovrs_q         <= ovrs_d;
            tmo_err        <= tmo_err_d;
            sweep_done     <= sweep_d;
            drp.drp_den    <= (state_d == REQ);
            drp.drp_daddr  <= ADDR_LIST[7*32'(ch_d) +: 7];
`ifdef XADC_SCAN_AVG_EN
            acc_q          <= acc_d;
            scnt_q         <= scnt_d;
            ovr_acc_q      <= ovr_acc_d;
`endif
        end
    end

    // Result bank: written once per channel per sweep
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                bank_q[i] <= '0;
            end
            ovr_q <= '0;
        end else if (bank_we_c) begin
            bank_q[ch_q] <= bank_wdata_c;
            ovr_q[ch_q]  <= bank_wovr_c;
        end
    end

    // Registered read port; a same-cycle write shows up one cycle later
    always_ff @(posedge pclk) begin
        if (rst) begin
            rd_data <= '0;
            rd_ovr  <= 1'b0;
        end else if (32'(rd_ch) < NUM_CH) begin
            rd_data <= bank_q[rd_ch];
            rd_ovr  <= ovr_q[rd_ch];
        end else begin
            rd_data <= '0;
            rd_ovr  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xadc_scan_sequencer.sv
// Directed bench for xadc_scan_sequencer with a small DRP responder model.
// Expected values adapt to whether XADC_SCAN_AVG_EN is defined.
module tb_xadc_scan_sequencer;

    localparam int unsigned NUM_CH      = 3;
    localparam int unsigned WAIT_CYCLES = 4;
    localparam int unsigned TMO_CYCLES  = 8;
    localparam int unsigned AVG_LOG2    = 2;
    localparam int unsigned DRDY_LAT    = 3;
    localparam int unsigned BOUND       = 400;
    localparam logic [6:0]  A0 = 7'h16;
    localparam logic [6:0]  A1 = 7'h17;
    localparam logic [6:0]  A2 = 7'h1E;
`ifdef XADC_SCAN_AVG_EN
    localparam int unsigned N_CONV      = 1 << AVG_LOG2;
    localparam logic [11:0] EXP_AVG     = 12'h280;  // (0x100+0x200+0x300+0x400)>>2
    localparam logic [11:0] EXP_OVR_MIX = 12'h9FF;  // (0xFFF+3*0x800)>>2
`else
    localparam int unsigned N_CONV      = 1;
    localparam logic [11:0] EXP_AVG     = 12'h100;  // single conversion of 0x1000
    localparam logic [11:0] EXP_OVR_MIX = 12'hFFF;  // single over-range conversion
`endif

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic [1:0]  rd_ch;
    logic [11:0] rd_data;
    logic        rd_ovr;
    logic        sweep_done;
    logic        tmo_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sweep_n  = 0;
    int          ch0_drdy_n = 0;
    logic        mute_ch1 = 1'b0;
    logic [15:0] ch2_bias = 16'h0;
    logic [15:0] ch0_q [$];

    xadc_scan_sequencer_if drp ();

    xadc_scan_sequencer #(
        .NUM_CH      (NUM_CH),
        .ADDR_LIST   ({A2, A1, A0}),
        .WAIT_CYCLES (WAIT_CYCLES),
        .AVG_LOG2    (AVG_LOG2),
        .OVR_THRESH  (16'hFFD0),
        .TMO_CYCLES  (TMO_CYCLES)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .drp        (drp.master),
        .rd_ch      (rd_ch),
        .rd_data    (rd_data),
        .rd_ovr     (rd_ovr),
        .sweep_done (sweep_done),
        .tmo_err    (tmo_err)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        if (sweep_done) sweep_n++;
    end

    // DRP responder: drdy DRDY_LAT cycles after den; ch0 data from a queue, else addr<<8
    initial begin : drp_model
        logic [6:0]  a;
        logic [15:0] d;
        drp.drp_drdy = 1'b0;
        drp.drp_do   = 16'h0;
        forever begin
            @(negedge pclk);
            if (drp.drp_den) begin
                a = drp.drp_daddr;
                if (a == A0 && ch0_q.size() > 0) d = ch0_q.pop_front();
                else d = 16'({a, 8'h00}) + ((a == A2) ? ch2_bias : 16'h0);
                if (!(mute_ch1 && a == A1)) begin
                    repeat (DRDY_LAT) @(negedge pclk);
                    drp.drp_drdy = 1'b1;
                    drp.drp_do   = d;
                    if (a == A0) ch0_drdy_n++;
                    @(negedge pclk);
                    drp.drp_drdy = 1'b0;
                    drp.drp_do   = 16'h0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_sweep(input string tag);
        int   n = 0;
        logic found = 1'b0;
        while (!found && n < BOUND) begin
            @(negedge pclk);
            n++;
            if (sweep_done) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_den(input logic [6:0] addr, input string tag);
        int   n = 0;
        logic found = 1'b0;
        while (!found && n < BOUND) begin
            @(negedge pclk);
            n++;
            if (drp.drp_den && drp.drp_daddr == addr) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_ch0_drdy(input int target, input string tag);
        int n = 0;
        while (ch0_drdy_n < target && n < BOUND) begin
            @(negedge pclk);
            #1;
            n++;
        end
        check(tag, 32'(ch0_drdy_n >= target), 32'd1);
    endtask

    task automatic read_ch(input logic [1:0] ch, input string tag,
                           input logic [11:0] exp_data, input logic exp_ovr);
        rd_ch = ch;
        @(negedge pclk);
        check({tag, "_data"}, 32'(rd_data), 32'(exp_data));
        check({tag, "_ovr"}, 32'(rd_ovr), 32'(exp_ovr));
    endtask

    task automatic count_first_den(input string tag);
        int   n = 0;
        logic found = 1'b0;
        while (!found && n < 50) begin
            @(negedge pclk);
            n++;
            if (drp.drp_den) found = 1'b1;
        end
        // IDLE is cycle 1, WAIT fills the next WAIT_CYCLES, den in the cycle after
        check(tag, 32'(n), 32'(WAIT_CYCLES + 1));
        check({tag, "_addr"}, 32'(drp.drp_daddr), 32'(A0));
    endtask

    initial begin : main
        int base;
        rd_ch = 2'd0;
        repeat (3) @(negedge pclk);

        check("rst_den", 32'(drp.drp_den), 32'd0);
        check("rst_daddr", 32'(drp.drp_daddr), 32'(A0));
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_ovr", 32'(rd_ovr), 32'd0);
        check("rst_sweep_done", 32'(sweep_done), 32'd0);
        check("rst_tmo_err", 32'(tmo_err), 32'd0);

        rst = 1'b0;
        count_first_den("first_den");
        read_ch(2'd1, "rst_bank1", 12'h000, 1'b0);
        read_ch(2'd2, "rst_bank2", 12'h000, 1'b0);

        // Sweep 1: plain addr<<8 responses
        wait_sweep("sweep1");
        @(negedge pclk);
        check("sweep_done_width", 32'(sweep_done), 32'd0);
        for (int i = 0; i < N_CONV; i++) ch0_q.push_back(16'((i + 1) * 16'h1000));
        read_ch(2'd0, "s1_ch0", 12'h160, 1'b0);
        read_ch(2'd1, "s1_ch1", 12'h170, 1'b0);
        read_ch(2'd2, "s1_ch2", 12'h1E0, 1'b0);
        check("sweep_count1", 32'(sweep_n), 32'd1);

        // Sweep 2: averaging, and read of ch0 across its own write cycle
        rd_ch = 2'd0;
        base = ch0_drdy_n;
        wait_ch0_drdy(base + N_CONV, "s2_ch0_drdy");
        @(negedge pclk);
        @(negedge pclk);
        check("same_cycle_old", 32'(rd_data), 32'h160);
        @(negedge pclk);
        check("same_cycle_new", 32'(rd_data), 32'(EXP_AVG));
        wait_sweep("sweep2");
        ch0_q.push_back(16'hFFE0);
        for (int i = 1; i < N_CONV; i++) ch0_q.push_back(16'h8000);
        read_ch(2'd0, "s2_ch0", EXP_AVG, 1'b0);
        check("sweep_count2", 32'(sweep_n), 32'd2);

        // Sweep 3: one over-range sample
        wait_sweep("sweep3");
        for (int i = 0; i < N_CONV; i++) ch0_q.push_back(16'h8000);
        read_ch(2'd0, "s3_ch0", EXP_OVR_MIX, 1'b1);
        read_ch(2'd3, "oob_ch", 12'h000, 1'b0);

        // Sweep 4: over-range flag clears
        wait_sweep("sweep4");
        for (int i = 0; i < N_CONV; i++) ch0_q.push_back(16'hFFD0);
        read_ch(2'd0, "s4_ch0", 12'h800, 1'b0);

        // Sweep 5: exactly at threshold is not over-range
        wait_sweep("sweep5");
        read_ch(2'd0, "s5_ch0_thresh", 12'hFFD, 1'b0);
        check("tmo_err_clear", 32'(tmo_err), 32'd0);
        mute_ch1 = 1'b1;
        ch2_bias = 16'h0050;

        // Sweep 6: channel 1 never answers
        wait_den(A1, "s6_ch1_den");
        repeat (TMO_CYCLES) @(negedge pclk);
        check("tmo_not_early", 32'(tmo_err), 32'd0);
        @(negedge pclk);
        check("tmo_set", 32'(tmo_err), 32'd1);
        wait_sweep("sweep6");
        read_ch(2'd0, "s6_ch0", 12'h160, 1'b0);
        read_ch(2'd1, "s6_ch1_kept", 12'h170, 1'b0);
        read_ch(2'd2, "s6_ch2", 12'h1E5, 1'b0);
        wait_sweep("sweep7");
        check("tmo_sticky", 32'(tmo_err), 32'd1);
        mute_ch1 = 1'b0;
        ch2_bias = 16'h0;

        // Reset while waiting for drdy; drdy lands in the cycle after reset
        wait_den(A0, "s8_ch0_den");
        repeat (2) @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
        check("mid_rst_den", 32'(drp.drp_den), 32'd0);
        check("mid_rst_daddr", 32'(drp.drp_daddr), 32'(A0));
        check("mid_rst_tmo_err", 32'(tmo_err), 32'd0);
        check("mid_rst_sweep_done", 32'(sweep_done), 32'd0);
        check("mid_rst_rd_data", 32'(rd_data), 32'd0);
        count_first_den("den_after_rst");
        read_ch(2'd2, "bank_cleared", 12'h000, 1'b0);
        rd_ch = 2'd0;
        wait_sweep("sweep_after_rst");
        read_ch(2'd0, "post_rst_ch0", 12'h160, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
